decoder_scan_ctrl: RTL

//  Upstream sequencer for the 2-to-4 decoder. Drives its select pair (a,b) and enable (e).
//  On a start request it walks the select through all four codes, holding each for DWELL cycles.

---
 rtl/decoder_scan_ctrl_pkg.sv | 25 ++
 rtl/decoder_scan_ctrl_dwell_timer.sv | 39 +++
 rtl/decoder_scan_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// rtl/decoder_scan_ctrl_pkg.sv - shared types and constants for the decoder scan sequencer
package decoder_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SEL_W = 2;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Code a sweep starts on: 00 when walking up, 11 when walking down.
  function automatic logic [SEL_W-1:0] first_code(input logic dir);
    return (dir == DIR_DN) ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
  endfunction

  // Code a sweep ends on is the start code of the opposite direction.
  function automatic logic [SEL_W-1:0] last_code(input logic dir);
    return first_code(~dir);
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// rtl/decoder_scan_ctrl_dwell_timer.sv - dwell counter, ticks on the last cycle of each dwell
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear outside a scan, wrap to zero on the tick, else count up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - sequences a 2-to-4 decoder select through a timed one-hot scan
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic mode_i,
  input  logic dir_i,
  output logic a_o,
  output logic b_o,
  output logic e_o,
  output logic busy_o,
  output logic done_o
);

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             e_q;
  logic             busy_q;
  logic             done_q;
  logic             mode_q;
  logic             dir_q;
  logic             tick;

  // The counter only runs while scanning and is held at zero otherwise,
  // so every scan starts with a full dwell on its first code.
  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_q != ST_RUN),
    .en_i   (state_q == ST_RUN),
    .tick_o (tick)
  );

  // Scan FSM; every output is a register so the decoder sees glitch-free select/enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_RUN;
            mode_q  <= mode_i;
            dir_q   <= dir_i;
            sel_q   <= first_code(dir_i);
            e_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          // An abort wins over a sweep completing on the same cycle.
          if (stop_i) begin
            state_q <= ST_IDLE;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (sel_q == last_code(dir_q)) begin
              if (mode_q) begin
                sel_q <= first_code(dir_q);
              end else begin
                state_q <= ST_DONE;
                e_q     <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              sel_q <= (dir_q == DIR_DN) ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          e_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o    = sel_q[1];
  assign b_o    = sel_q[0];
  assign e_o    = e_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
